// File: rtl/rf_pkg.sv
// Shared register-file definitions, also used by rf_decode.
package rf_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NREGS     = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xword_t;

    // One-hot write-enable vector for a single destination register.
    function automatic logic [NREGS-1:0] onehot_dec(input reg_idx_t idx);
        logic [NREGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rf_read_stage_if.sv
// Write-side and read-side bus of the register-file read stage.
interface rf_read_stage_if #(
    parameter int unsigned XLEN  = rf_pkg::XLEN,
    parameter int unsigned NREGS = rf_pkg::NREGS
) ();

    logic [NREGS-1:0]         write_dec;
    logic [XLEN-1:0]          write_data;
    logic [$clog2(NREGS)-1:0] rs1;
    logic [$clog2(NREGS)-1:0] rs2;
    logic                     read_en;
    logic [XLEN-1:0]          rs1_data;
    logic [XLEN-1:0]          rs2_data;
    logic                     rd_valid;

    modport master (
        output write_dec, write_data, rs1, rs2, read_en,
        input  rs1_data, rs2_data, rd_valid
    );

    modport slave (
        input  write_dec, write_data, rs1, rs2, read_en,
        output rs1_data, rs2_data, rd_valid
    );

endinterface

// File: rtl/rf_read_mux.sv
// Combinational NREGS:1 read select with x0 forced to zero.
// Write-to-read forwarding is compiled in when RF_BYPASS_EN is defined.
module rf_read_mux
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = rf_pkg::XLEN,
    parameter int unsigned NREGS = rf_pkg::NREGS
) (
    input  logic [NREGS-1:0][XLEN-1:0] rf_view,
    input  logic [$clog2(NREGS)-1:0]   rd_addr,
    input  logic [NREGS-1:0]           write_dec,
    input  logic [XLEN-1:0]            write_data,
    output logic [XLEN-1:0]            rd_data
);

`ifdef RF_BYPASS_EN
    always_comb begin
        rd_data = rf_view[rd_addr];
        if (write_dec[rd_addr]) begin
            rd_data = write_data;
        end
        if (rd_addr == '0) begin
            rd_data = '0;
        end
    end
`else
    // Write side is only consumed by the forwarding path.
    logic unused_write_side;
    assign unused_write_side = ^{write_dec, write_data};

    always_comb begin
        rd_data = rf_view[rd_addr];
        if (rd_addr == '0) begin
            rd_data = '0;
        end
    end
`endif

endmodule

// File: rtl/rf_read_stage.sv
// Register-file storage (x1..x31) with two registered read ports.
// Optional same-edge write-to-read forwarding: define RF_BYPASS_EN.
module rf_read_stage
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = rf_pkg::XLEN,
    parameter int unsigned NREGS = rf_pkg::NREGS
) (
    input  logic                clk,
    input  logic                rst,
    rf_read_stage_if.slave      bus
);

    logic [NREGS-1:1][XLEN-1:0] regs;
    logic [NREGS-1:0][XLEN-1:0] rf_view;
    logic [XLEN-1:0]            rs1_next;
    logic [XLEN-1:0]            rs2_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                if (bus.write_dec[i]) begin
                    regs[i] <= bus.write_data;
                end
            end
        end
    end

    // x0 has no storage; a zero slot keeps the mux a plain full-range select.
    always_comb begin
        rf_view          = '0;
        rf_view[NREGS-1:1] = regs;
    end

    rf_read_mux #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_mux_rs1 (
        .rf_view    (rf_view),
        .rd_addr    (bus.rs1),
        .write_dec  (bus.write_dec),
        .write_data (bus.write_data),
        .rd_data    (rs1_next)
    );

    rf_read_mux #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_mux_rs2 (
        .rf_view    (rf_view),
        .rd_addr    (bus.rs2),
        .write_dec  (bus.write_dec),
        .write_data (bus.write_data),
        .rd_data    (rs2_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rs1_data <= '0;
            bus.rs2_data <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= bus.read_en;
            if (bus.read_en) begin
                bus.rs1_data <= rs1_next;
                bus.rs2_data <= rs2_next;
            end
        end
    end

endmodule

// File: tb/tb_rf_read_stage.sv
// Directed-vector bench for rf_read_stage; expectations follow RF_BYPASS_EN.
module tb_rf_read_stage;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rf_read_stage_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

    rf_read_stage #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NREGS-1:0] wd, input logic [31:0] wdata,
                         input logic re, input int unsigned a1, input int unsigned a2);
        bus.write_dec  = wd;
        bus.write_data = wdata;
        bus.read_en    = re;
        bus.rs1        = reg_idx_t'(a1);
        bus.rs2        = reg_idx_t'(a2);
    endtask

    task automatic check_out(input string tag, input logic [31:0] e1, input logic [31:0] e2, input logic ev);
        check_val({tag, ".rs1"}, bus.rs1_data, e1);
        check_val({tag, ".rs2"}, bus.rs2_data, e2);
        check_val({tag, ".vld"}, {31'd0, bus.rd_valid}, {31'd0, ev});
    endtask

    logic [31:0] exp_same;

    initial begin
`ifdef RF_BYPASS_EN
        exp_same = 32'h1234_5678;
`else
        exp_same = 32'h0000_0011;
`endif
        drive('0, '0, 1'b0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Prior writes, then a 2-cycle reset carrying a read request.
        drive(onehot_dec(5), 32'h5555_5555, 1'b0, 0, 0); step();
        drive(onehot_dec(7), 32'h7777_7777, 1'b0, 0, 0); step();
        rst = 1'b1;
        drive('0, '0, 1'b1, 5, 7);
        step(); check_out("rst_c1", 32'h0, 32'h0, 1'b0);
        step(); check_out("rst_c2", 32'h0, 32'h0, 1'b0);
        rst = 1'b0;

        for (int unsigned i = 0; i < NREGS; i++) begin
            drive('0, '0, 1'b1, i, NREGS - 1 - i);
            step();
            check_val("post_rst.rs1", bus.rs1_data, 32'h0);
            check_val("post_rst.rs2", bus.rs2_data, 32'h0);
        end
        check_val("post_rst.vld", {31'd0, bus.rd_valid}, 32'd1);

        // Write then read.
        drive(onehot_dec(3), 32'hDEAD_BEEF, 1'b0, 0, 0); step();
        check_val("idle.vld", {31'd0, bus.rd_valid}, 32'd0);
        drive('0, '0, 1'b1, 3, 0); step();
        check_out("wr_rd", 32'hDEAD_BEEF, 32'h0, 1'b1);

        // x0 write is ignored.
        drive(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0, 0); step();
        drive('0, '0, 1'b1, 0, 3); step();
        check_out("x0", 32'h0, 32'hDEAD_BEEF, 1'b1);

        // Top register and multi-hot write.
        drive(onehot_dec(31), 32'h8000_0001, 1'b0, 0, 0); step();
        drive(onehot_dec(20) | onehot_dec(21), 32'h0000_CAFE, 1'b0, 0, 0); step();
        drive('0, '0, 1'b1, 31, 1); step();
        check_out("x31", 32'h8000_0001, 32'h0, 1'b1);
        drive('0, '0, 1'b1, 20, 21); step();
        check_out("multihot", 32'h0000_CAFE, 32'h0000_CAFE, 1'b1);

        // Same-edge write and read.
        drive(onehot_dec(10), 32'h0000_0011, 1'b0, 0, 0); step();
        drive(onehot_dec(10), 32'h1234_5678, 1'b1, 10, 10); step();
        check_out("same_cyc", exp_same, exp_same, 1'b1);
        drive('0, '0, 1'b1, 10, 10); step();
        check_out("next_cyc", 32'h1234_5678, 32'h1234_5678, 1'b1);

        // Hold: writes land, outputs keep their values.
        drive('0, '0, 1'b1, 3, 0); step();
        check_out("pre_hold", 32'hDEAD_BEEF, 32'h0, 1'b1);
        for (int unsigned i = 0; i < 3; i++) begin
            drive(onehot_dec(3), 32'hA5A5_A5A5, 1'b0, 10, 10);
            step();
            check_out("hold", 32'hDEAD_BEEF, 32'h0, 1'b0);
        end
        drive('0, '0, 1'b1, 3, 0); step();
        check_out("unhold", 32'hA5A5_A5A5, 32'h0, 1'b1);

        // Reset mid-operation discards the write and the read.
        rst = 1'b1;
        drive(onehot_dec(4), 32'h0000_0055, 1'b1, 3, 4); step();
        check_out("mid_rst", 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        drive('0, '0, 1'b1, 3, 4); step();
        check_out("after_mid_rst", 32'h0, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_read_stage.md
# rf_read_stage

Register-file storage and read stage for the RISC-V core. Holds x1–x31, takes the one-hot write-enable vector from `rf_decode` on the write side, and gives two registered read ports (rs1, rs2) to the decode/execute boundary. Read data appears one cycle after the request. The stage supports stall/hold and optional same-cycle write-to-read bypass.

## Interface
Parameters:
- XLEN, 32, data width of each register and read port.
- NREGS, 32, register count; index width is log2(NREGS) = 5.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- write_dec  input  NREGS  one-hot write enables from `rf_decode`. Bit 0 is ignored.
- write_data  input  XLEN  data written to every register whose write_dec bit is high.
- rs1  input  5  read address, port 1.
- rs2  input  5  read address, port 2.
- read_en  input  1  capture a new read this cycle. When low, the outputs hold.
- rs1_data  output  XLEN  registered port-1 data.
- rs2_data  output  XLEN  registered port-2 data.
- rd_valid  output  1  high in the cycle after a cycle with read_en high.

## Operation
- Storage: regs[1..31], each XLEN wide. x0 has no storage and always reads 0.
- Write: on the clk edge, regs[i] <= write_data for each i in 1..31 where write_dec[i]=1.
  - Multi-hot write_dec is outside the protocol. It is still defined: every flagged register is written with the same data.
- Read: on the clk edge with read_en=1:
  - rs1_data <= value(rs1), rs2_data <= value(rs2).
  - value(0) is always 0.
  - value(r) for r≠0 is the pre-edge content of regs[r], unless bypass applies (see Configuration).
- Hold: with read_en=0, rs1_data and rs2_data keep their values and rd_valid <= 0.
  - Writes still take effect during hold. Held outputs are not refreshed.
- rs1 == rs2: both ports return the same value.
- Reset (rst=1 at an edge) takes priority over write and read:
  - regs[1..31] <= 0, rs1_data <= 0, rs2_data <= 0, rd_valid <= 0.
  - A read or write presented in the reset cycle is discarded.
  - After reset, every register reads 0.

## Timing
- Read latency: 1 cycle. Request at edge N is visible on the outputs after edge N.
- Write latency: 1 cycle to storage. A write at edge N is seen by a read captured at edge N+1 or later. Same-edge visibility depends on RF_BYPASS_EN.
- rd_valid is a registered copy of read_en, gated by rst.
- No combinational path from inputs to outputs.
- Reset values: rs1_data=0, rs2_data=0, rd_valid=0.

## Configuration
- Macro RF_BYPASS_EN.
- Defined: at a read edge, if write_dec[r]=1 for a port address r≠0, that port captures write_data (write-to-read forward). This is evaluated per port.
- Undefined: the read port captures the old storage value. The new value is visible from the next read.
- x0 reads 0 in both builds.

## Structure
- Shared package `rf_pkg`:
  - XLEN=32, NREGS=32, REG_IDX_W=5.
  - Typedefs reg_idx_t (5 bits) and xword_t (XLEN bits).
  - `rf_decode` uses the same package.
- Sub-module `rf_read_mux`: combinational 32:1 select with x0 forced to 0 and the optional bypass term. It is instantiated once per read port. The output flops live in `rf_read_stage`.

## Test plan
- Reset: hold rst for 2 cycles with read_en=1, rs1=5, rs2=7 after prior writes → rs1_data=0, rs2_data=0, rd_valid=0. The first read after reset returns 0 for all indices.
- Write then read: write_dec=1<<3, write_data=0xDEADBEEF. Next cycle read rs1=3, rs2=0 with read_en=1 → rs1_data=0xDEADBEEF, rs2_data=0, rd_valid=1.
- x0 guard: force write_dec=0x00000001, write_data=0xFFFFFFFF. Then read rs1=0 → rs1_data=0.
- Same-cycle write/read: write_dec=1<<10, write_data=0x12345678 with regs[10]=0x11, read rs1=10 in the same cycle.
  - Result: rs1_data=0x12345678 with RF_BYPASS_EN, 0x11 without.
  - A read on the next cycle returns 0x12345678 in both builds.
- Hold:
  - Read rs1=3 (0xDEADBEEF), then read_en=0 for 3 cycles while writing regs[3]=0xA5A5A5A5 → rs1_data stays 0xDEADBEEF and rd_valid=0.
  - Re-enabling read_en returns 0xA5A5A5A5.
- Reset mid-operation: rst asserted in the same cycle as write_dec=1<<4, write_data=0x55 and read_en=1 → the write is discarded. A later read of rs2=4 returns 0 and outputs are 0 during reset.
